// File: rtl/id_fetch_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: default widths,
// delay-slot setting and the {pc, inst} entry shape used by IF and ID.
package id_fetch_queue_pkg;

  localparam int PC_W_DEF       = 32;
  localparam int INST_W_DEF     = 32;
  localparam int DELAY_SLOT_DEF = 1;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fq_entry_t;

  // Pointer width for a queue of n entries (n a power of two).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/id_fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port; contents are not reset, only the pointers are.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_fetch_queue.sv
// IF->ID instruction queue: reserves a slot per SRAM read, captures the
// response a cycle later, bypasses to ID when empty, squashes on taken branch.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PC_W       = PC_W_DEF,
  parameter int INST_W     = INST_W_DEF,
  parameter int DELAY_SLOT = DELAY_SLOT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [PC_W-1:0]       fetch_pc,
  output logic                  fetch_ready,
  input  logic [INST_W-1:0]     inst_sram_rdata,
  output logic                  id_valid,
  output logic [PC_W-1:0]       id_pc,
  output logic [INST_W-1:0]     id_inst,
  input  logic                  id_ready,
  input  logic                  flush,
  output logic [clog2(DEPTH):0] count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             infl_v, squash;
  logic [PC_W-1:0]  pc_q;

  logic   accept, empty, live, pop, pop_stored, mem_we;
  logic   keep_stored, keep_live, keep_req;
  entry_t live_entry, mem_rdata, head_entry;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid never depends on ready, and fetch_ready depends only on registered state.
  assign fetch_ready = (count_q + CNT_W'(infl_v)) < CNT_W'(DEPTH);
  assign accept      = fetch_valid & fetch_ready;
  assign empty       = (count_q == '0);
  assign live        = infl_v & ~squash;

  assign live_entry  = {pc_q, inst_sram_rdata};
  assign head_entry  = empty ? live_entry : mem_rdata;
  assign id_valid    = ~empty | live;
  assign id_pc       = id_valid ? head_entry.pc : '0;
  assign id_inst     = id_valid ? head_entry.inst : '0;
  assign count       = count_q;

  assign pop        = id_valid & id_ready;
  assign pop_stored = pop & ~empty;

  // Delay-slot candidate in age order: next stored entry, then the live
  // response, then this cycle's request. With an empty queue the head is the live one.
  assign keep_stored = (DELAY_SLOT == 1) && !empty && (count_q > CNT_W'(1));
  assign keep_live   = (DELAY_SLOT == 1) && (count_q == CNT_W'(1)) && live;
  assign keep_req    = (DELAY_SLOT == 1) && !keep_stored && !keep_live && accept;

  assign mem_we = flush ? keep_live : (live & ~(empty & id_ready));

  fetch_queue_mem #(
    .DEPTH(DEPTH),
    .WIDTH($bits(entry_t)),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(live_entry),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      infl_v  <= 1'b0;
      squash  <= 1'b0;
      pc_q    <= '0;
    end else begin
      infl_v <= accept;
      if (accept) pc_q <= fetch_pc;
      if (flush) begin
        squash <= accept & ~keep_req;
        if (keep_stored) begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          wr_ptr  <= rd_ptr + PTR_W'(2);
          count_q <= CNT_W'(1);
        end else if (keep_live) begin
          rd_ptr  <= wr_ptr;
          wr_ptr  <= wr_ptr + PTR_W'(1);
          count_q <= CNT_W'(1);
        end else begin
          rd_ptr  <= wr_ptr;
          count_q <= '0;
        end
      end else begin
        squash <= 1'b0;
        if (mem_we) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_stored) rd_ptr <= rd_ptr + PTR_W'(1);
        count_q <= count_q + CNT_W'(mem_we) - CNT_W'(pop_stored);
      end
    end
  end

endmodule
